ccd_line_ctrl: RTL and testbench
================================

// Module: ccd_line_ctrl
// PURPOSE
// Sequencer for the TCD1209D line-scan sensor chain. After reset it waits for
// power-up, loads the AD9945 configuration, then runs continuous line capture:
// frames each line on sh, counts pixels on tvalid, and applies host gain and
// integration-time updates only at line boundaries. Sits between the host
// register file and the top-level sensor wrapper (drives f1_cnt, VGA_Gain, cfg_en).
// PARAMETERS
// SAMP_NUM    12'd2088  pixels (tvalid beats) per line
// PWRUP_CYC   16'd1000  sys_clk cycles from enable to first config
// CFG_CYC     16'd256   cycles reserved after a cfg_en pulse for the serial write
// F1_DEF      10'd10    f1_cnt value after reset
// GAIN_DEF    10'd0     VGA_Gain value after reset
// TMO_CYC     24'd2000000 line watchdog limit (used only with CCD_LINE_TMO_EN)
// PORTS
// sys_clk     in   1   system clock
// rst_n       in   1   asynchronous active-low reset
// enable      in   1   run request; low forces IDLE
// upd_req     in   1   host update request, held until upd_ack
// upd_gain    in   10  new VGA gain
// upd_f1      in   10  new integration count
// upd_ack     out  1   one-cycle accept pulse
// sh          in   1   shift gate from sensor driver
// tvalid      in   1   pixel strobe from AFE driver
// f1_cnt      out  10  integration count to sensor driver
// VGA_Gain    out  10  gain to AD9945 config
// cfg_en      out  1   one-cycle config start pulse
// line_start  out  1   one-cycle pulse on sh rising edge in RUN
// line_done   out  1   one-cycle pulse on SAMP_NUM-th tvalid
// line_cnt    out  16  completed lines, wraps 16'hFFFF->0
// pix_err     out  1   sticky pixel-count error, cleared on IDLE
// busy        out  1   high in any state except IDLE and RUN
// BEHAVIOUR
// - Reset: state IDLE; f1_cnt=F1_DEF, VGA_Gain=GAIN_DEF; all other outputs 0.
// - States: IDLE -> PWRUP (enable=1) -> CFG -> CFG_WAIT -> RUN;
//   RUN -> RECFG -> CFG_WAIT -> RUN on accepted update.
// - PWRUP counts PWRUP_CYC cycles. CFG drives cfg_en=1 exactly one cycle.
//   CFG_WAIT counts CFG_CYC cycles, then RUN.
// - enable=0 in any state: IDLE next cycle; counters, pix_err cleared;
//   f1_cnt/VGA_Gain keep last values.
// - sh edge detect is registered (1-cycle latency); line_start one cycle after
//   the sampled rise. Pixel counter (12 bit) clears on line_start.
// - tvalid counts only in RUN after the first line_start; on reaching SAMP_NUM:
//   line_done=1, line_cnt+1, counter holds at SAMP_NUM until next line_start.
// - pix_err set if: line_start with 0<count<SAMP_NUM (short line), or tvalid
//   with count==SAMP_NUM (long line). Line_start and line_done same cycle:
//   line_done counted first, no error.
// - Update accept only in RUN when line_done=1 or no line in progress (before
//   first line_start): latch upd_gain->VGA_Gain, upd_f1->f1_cnt, upd_ack=1
//   one cycle, then RECFG (cfg_en pulse) -> CFG_WAIT. Requests outside accept
//   windows wait; upd_req dropped before ack is ignored.
// - sh/tvalid outside RUN ignored; pixel counter cleared entering RUN.
// CONFIGURATION
// CCD_LINE_TMO_EN defined: 24-bit watchdog in RUN, cleared on line_start; on
//   reaching TMO_CYC sets pix_err and goes to CFG (full reconfig).
// Not defined: no watchdog; RUN waits indefinitely for sh; TMO_CYC unused.
// TESTING
// 1 Reset, enable=1 -> cfg_en pulse at cycle PWRUP_CYC+1, busy low after
//   further CFG_CYC cycles, f1_cnt=10, VGA_Gain=0.
// 2 Three lines of 2088 tvalid each -> 3 line_start, 3 line_done, line_cnt=3,
//   pix_err=0.
// 3 Line with 2000 tvalid then sh -> pix_err=1; line with 2089 -> pix_err=1.
// 4 upd_req gain=10'h155,f1=40 mid-line -> upd_ack on line_done cycle, then
//   VGA_Gain=10'h155, f1_cnt=40, cfg_en one cycle later.
// 5 enable=0 at pixel 1000 -> IDLE next cycle, pix_err=0, line_cnt=0.
// 6 CCD_LINE_TMO_EN, TMO_CYC=500, no sh -> pix_err=1 and cfg_en after 500 cycles.

Source files
------------

// File: rtl/ccd_line_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ccd_line_ctrl_if
// Description : Host update handshake between the register file and
//               ccd_line_ctrl. The host raises upd_req with the new gain and
//               integration count and holds it until upd_ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface ccd_line_ctrl_if;
  logic       upd_req;
  logic [9:0] upd_gain;
  logic [9:0] upd_f1;
  logic       upd_ack;

  // Host side: raises the request and waits for the accept pulse
  modport master (
    output upd_req,
    output upd_gain,
    output upd_f1,
    input  upd_ack
  );

  // Sequencer side: samples the request and returns the accept pulse
  modport slave (
    input  upd_req,
    input  upd_gain,
    input  upd_f1,
    output upd_ack
  );
endinterface
`default_nettype wire

// File: rtl/ccd_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ccd_line_ctrl
// Description : Sequencer for the TCD1209D / AD9945 line-scan chain. Waits
//               for power-up, issues the AFE configuration pulse, then runs
//               continuous line capture: frames lines on sh, counts pixels on
//               tvalid, flags short/long lines, and applies host gain and
//               integration updates only at line boundaries.
//               Optional feature macro: CCD_LINE_TMO_EN (line watchdog that
//               forces a full reconfiguration when sh stops arriving).
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_line_ctrl #(
  parameter logic [11:0] SAMP_NUM  = 12'd2088,
  parameter logic [15:0] PWRUP_CYC = 16'd1000,
  parameter logic [15:0] CFG_CYC   = 16'd256,
  parameter logic [9:0]  F1_DEF    = 10'd10,
  parameter logic [9:0]  GAIN_DEF  = 10'd0,
  parameter logic [23:0] TMO_CYC   = 24'd2000000
) (
  input  wire logic        sys_clk,
  input  wire logic        rst_n,
  input  wire logic        enable,
  ccd_line_ctrl_if.slave   upd,
  input  wire logic        sh,
  input  wire logic        tvalid,
  output logic [9:0]       f1_cnt,
  output logic [9:0]       VGA_Gain,
  output logic             cfg_en,
  output logic             line_start,
  output logic             line_done,
  output logic [15:0]      line_cnt,
  output logic             pix_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWRUP    = 3'd1,
    S_CFG      = 3'd2,
    S_CFG_WAIT = 3'd3,
    S_RUN      = 3'd4,
    S_RECFG    = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;        // shared cycle counter for PWRUP and CFG_WAIT
  logic [11:0] r_pix_cnt;    // tvalid beats in the current line
  logic        r_line_act;   // a line_start has been seen since entering RUN
  logic        r_sh_d;       // previous sh sample for edge detection
  logic [9:0]  r_f1;
  logic [9:0]  r_gain;
  logic        r_cfg_en;
  logic        r_upd_ack;
  logic        r_line_start;
  logic        r_line_done;
  logic [15:0] r_line_cnt;
  logic        r_pix_err;
  logic        r_busy;

  logic        w_run;
  logic        w_sh_rise;
  logic        w_tv;
  logic        w_at_max;
  logic        w_done;
  logic        w_long;
  logic [11:0] w_pix_next;
  logic        w_short;
  logic        w_accept;

`ifdef CCD_LINE_TMO_EN
  logic [23:0] r_tmo;        // RUN cycles since the last line_start
  logic        w_tmo_hit;
`else
  logic [23:0] w_unused_tmo;
  assign w_unused_tmo = TMO_CYC;
`endif

  assign w_run     = (r_state == S_RUN);
  assign w_sh_rise = sh & ~r_sh_d;

  // Pixels count only once a line has been framed in RUN
  assign w_tv     = w_run & r_line_act & tvalid;
  assign w_at_max = (r_pix_cnt == SAMP_NUM);
  assign w_done   = w_tv & (r_pix_cnt == (SAMP_NUM - 12'd1));
  assign w_long   = w_tv & w_at_max;

  // Count including this cycle's beat; saturates at SAMP_NUM
  assign w_pix_next = (w_tv && !w_at_max) ? (r_pix_cnt + 12'd1) : r_pix_cnt;

  // A new line arriving before the previous one completed. The beat on the
  // same cycle belongs to the old line, so a line that completes exactly as
  // the next one starts is not short.
  assign w_short = w_run & w_sh_rise & r_line_act &
                   (w_pix_next != 12'd0) & (w_pix_next < SAMP_NUM);

  // Updates only land at a line boundary, or while no line is yet framed
  assign w_accept = w_run & upd.upd_req &
                    (w_done | (~r_line_act & ~w_sh_rise));

`ifdef CCD_LINE_TMO_EN
  assign w_tmo_hit = w_run & ~w_sh_rise & (r_tmo == (TMO_CYC - 24'd1));
`endif

  // Sequencer state, line accounting and all registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_pix_cnt    <= 12'd0;
      r_line_act   <= 1'b0;
      r_sh_d       <= 1'b0;
      r_f1         <= F1_DEF;
      r_gain       <= GAIN_DEF;
      r_cfg_en     <= 1'b0;
      r_upd_ack    <= 1'b0;
      r_line_start <= 1'b0;
      r_line_done  <= 1'b0;
      r_line_cnt   <= 16'd0;
      r_pix_err    <= 1'b0;
      r_busy       <= 1'b0;
`ifdef CCD_LINE_TMO_EN
      r_tmo        <= 24'd0;
`endif
    end else begin
      r_sh_d       <= sh;
      r_cfg_en     <= 1'b0;
      r_upd_ack    <= 1'b0;
      r_line_start <= 1'b0;
      r_line_done  <= 1'b0;

      if (!enable) begin
        // Drop everything except the applied gain/integration settings
        r_state    <= S_IDLE;
        r_cnt      <= 16'd0;
        r_pix_cnt  <= 12'd0;
        r_line_act <= 1'b0;
        r_line_cnt <= 16'd0;
        r_pix_err  <= 1'b0;
        r_busy     <= 1'b0;
`ifdef CCD_LINE_TMO_EN
        r_tmo      <= 24'd0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_PWRUP;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b1;
          end

          S_PWRUP: begin
            if (r_cnt == (PWRUP_CYC - 16'd1)) begin
              r_state  <= S_CFG;
              r_cfg_en <= 1'b1;
              r_cnt    <= 16'd0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          S_CFG: begin
            r_state <= S_CFG_WAIT;
            r_cnt   <= 16'd0;
          end

          S_RECFG: begin
            r_cfg_en <= 1'b1;
            r_state  <= S_CFG_WAIT;
            r_cnt    <= 16'd0;
          end

          S_CFG_WAIT: begin
            if (r_cnt == (CFG_CYC - 16'd1)) begin
              r_state    <= S_RUN;
              r_busy     <= 1'b0;
              r_pix_cnt  <= 12'd0;
              r_line_act <= 1'b0;
`ifdef CCD_LINE_TMO_EN
              r_tmo      <= 24'd0;
`endif
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          S_RUN: begin
            r_line_start <= w_sh_rise;

            if (w_done) begin
              r_line_done <= 1'b1;
              r_line_cnt  <= r_line_cnt + 16'd1;
            end

            if (w_short || w_long) begin
              r_pix_err <= 1'b1;
            end

            if (w_sh_rise) begin
              r_pix_cnt  <= 12'd0;
              r_line_act <= 1'b1;
            end else begin
              r_pix_cnt <= w_pix_next;
            end

`ifdef CCD_LINE_TMO_EN
            if (w_sh_rise) begin
              r_tmo <= 24'd0;
            end else begin
              r_tmo <= r_tmo + 24'd1;
            end
`endif

            if (w_accept) begin
              r_gain     <= upd.upd_gain;
              r_f1       <= upd.upd_f1;
              r_upd_ack  <= 1'b1;
              r_state    <= S_RECFG;
              r_busy     <= 1'b1;
              r_line_act <= 1'b0;
`ifdef CCD_LINE_TMO_EN
            end else if (w_tmo_hit) begin
              // sh has stopped: rerun the full AFE configuration
              r_pix_err  <= 1'b1;
              r_cfg_en   <= 1'b1;
              r_state    <= S_CFG;
              r_busy     <= 1'b1;
              r_line_act <= 1'b0;
              r_tmo      <= 24'd0;
`endif
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign upd.upd_ack = r_upd_ack;
  assign f1_cnt      = r_f1;
  assign VGA_Gain    = r_gain;
  assign cfg_en      = r_cfg_en;
  assign line_start  = r_line_start;
  assign line_done   = r_line_done;
  assign line_cnt    = r_line_cnt;
  assign pix_err     = r_pix_err;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ccd_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccd_line_ctrl
// Description : Directed self-checking bench for ccd_line_ctrl: power-up and
//               configuration timing, full lines, short/long line errors,
//               line-boundary host update, and enable drop mid-line.
//               With CCD_LINE_TMO_EN defined it exercises the line watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_line_ctrl;

    localparam int SAMP  = 2088;
    localparam int PWRUP = 1000;
    localparam int CFGC  = 256;
    localparam int TMO   = 500;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sh;
    logic        tvalid;
    logic [9:0]  f1_cnt;
    logic [9:0]  VGA_Gain;
    logic        cfg_en;
    logic        line_start;
    logic        line_done;
    logic [15:0] line_cnt;
    logic        pix_err;
    logic        busy;

    ccd_line_ctrl_if u_if ();

    ccd_line_ctrl #(
        .SAMP_NUM  (12'd2088),
        .PWRUP_CYC (16'd1000),
        .CFG_CYC   (16'd256),
        .F1_DEF    (10'd10),
        .GAIN_DEF  (10'd0),
        .TMO_CYC   (24'd500)
    ) u_dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .upd        (u_if.slave),
        .sh         (sh),
        .tvalid     (tvalid),
        .f1_cnt     (f1_cnt),
        .VGA_Gain   (VGA_Gain),
        .cfg_en     (cfg_en),
        .line_start (line_start),
        .line_done  (line_done),
        .line_cnt   (line_cnt),
        .pix_err    (pix_err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_ls  = 0;
    int n_ld  = 0;
    int n_ack = 0;
    int n     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (line_start)   n_ls++;
        if (line_done)    n_ld++;
        if (u_if.upd_ack) n_ack++;
    endtask

    // Raise sh for one sampled edge; line_start is visible after it
    task automatic start_line();
        sh = 1'b1;
        tick();
        sh = 1'b0;
    endtask

    task automatic beats(input int cnt);
        tvalid = 1'b1;
        repeat (cnt) tick();
        tvalid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        sh             = 1'b0;
        tvalid         = 1'b0;
        u_if.upd_req   = 1'b0;
        u_if.upd_gain  = 10'd0;
        u_if.upd_f1    = 10'd0;

        // Reset values
        repeat (3) tick();
        chk("rst_f1",   f1_cnt,       10'd10);
        chk("rst_gain", VGA_Gain,     10'd0);
        chk("rst_cfg",  cfg_en,       1'b0);
        chk("rst_busy", busy,         1'b0);
        chk("rst_lcnt", line_cnt,     16'd0);
        chk("rst_err",  pix_err,      1'b0);
        chk("rst_ack",  u_if.upd_ack, 1'b0);

        // Power-up: cfg_en on cycle PWRUP+1, then CFG_CYC+1 cycles busy
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (PWRUP) tick();
        chk("pwr_cfg_lo", cfg_en, 1'b0);
        chk("pwr_busy",   busy,   1'b1);
        tick();
        chk("cfg_pulse",  cfg_en, 1'b1);
        tick();
        chk("cfg_pulse_end", cfg_en, 1'b0);
        repeat (CFGC - 1) tick();
        chk("cfgw_busy", busy, 1'b1);
        tick();
        chk("run_busy", busy,     1'b0);
        chk("run_f1",   f1_cnt,   10'd10);
        chk("run_gain", VGA_Gain, 10'd0);

`ifdef CCD_LINE_TMO_EN
        // Watchdog: no sh in RUN -> reconfig after TMO cycles with pix_err set
        n = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            tick();
            n++;
            if (cfg_en) break;
        end
        chk("tmo_cycles", n,       TMO);
        chk("tmo_err",    pix_err, 1'b1);
        chk("tmo_busy",   busy,    1'b1);
`else
        // Three complete lines
        n_ls = 0;
        n_ld = 0;
        for (int l = 0; l < 3; l++) begin
            start_line();
            beats(SAMP);
        end
        chk("l3_starts", n_ls,     3);
        chk("l3_dones",  n_ld,     3);
        chk("l3_lcnt",   line_cnt, 16'd3);
        chk("l3_err",    pix_err,  1'b0);

        // Update requested mid-line is accepted on the line_done cycle
        n_ack = 0;
        start_line();
        chk("upd_ls", line_start, 1'b1);
        tvalid = 1'b1;
        repeat (1000) tick();
        u_if.upd_req  = 1'b1;
        u_if.upd_gain = 10'h155;
        u_if.upd_f1   = 10'd40;
        repeat (SAMP - 1001) tick();
        chk("upd_no_early", n_ack,    0);
        chk("upd_old_gain", VGA_Gain, 10'd0);
        tick();
        chk("upd_ack",  u_if.upd_ack, 1'b1);
        chk("upd_done", line_done,    1'b1);
        chk("upd_gain", VGA_Gain,     10'h155);
        chk("upd_f1",   f1_cnt,       10'd40);
        chk("upd_cfg0", cfg_en,       1'b0);
        chk("upd_lcnt", line_cnt,     16'd4);
        u_if.upd_req = 1'b0;
        tvalid       = 1'b0;
        tick();
        chk("upd_cfg1", cfg_en,       1'b1);
        chk("upd_ack0", u_if.upd_ack, 1'b0);
        n = 0;
        for (int i = 0; i < CFGC + 10; i++) begin
            if (!busy) break;
            tick();
            n++;
        end
        chk("upd_wait", n,     CFGC);
        chk("upd_acks", n_ack, 1);

        // Short line: 2000 beats, then next sh
        start_line();
        beats(2000);
        chk("short_pre", pix_err, 1'b0);
        start_line();
        chk("short_err",  pix_err,  1'b1);
        chk("short_lcnt", line_cnt, 16'd4);

        // enable dropped at pixel 1000
        beats(1000);
        enable = 1'b0;
        tick();
        chk("dis_busy", busy,     1'b0);
        chk("dis_err",  pix_err,  1'b0);
        chk("dis_lcnt", line_cnt, 16'd0);
        chk("dis_f1",   f1_cnt,   10'd40);
        chk("dis_gain", VGA_Gain, 10'h155);

        // Re-enable, then a long line of 2089 beats
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < PWRUP + 10; i++) begin
            tick();
            n++;
            if (cfg_en) break;
        end
        chk("re_cfg", n, PWRUP + 1);
        n = 0;
        for (int i = 0; i < CFGC + 10; i++) begin
            if (!busy) break;
            tick();
            n++;
        end
        chk("re_run", n, CFGC + 1);
        start_line();
        beats(SAMP);
        chk("long_done", line_done, 1'b1);
        chk("long_pre",  pix_err,   1'b0);
        chk("long_lcnt", line_cnt,  16'd1);
        beats(1);
        chk("long_err", pix_err,   1'b1);
        chk("long_nd",  line_done, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
